kb_fifo_ctrl: RTL and testbench

//   Bus-slave keyboard controller: buffers scan codes from the keyboard scanner in a

---
 rtl/kb_fifo_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_kb_fifo_ctrl.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_fifo_ctrl.sv
// kb_fifo_ctrl: bus-slave keyboard controller.
// Scan codes from the keyboard scanner are queued in a small FIFO so that bursts
// survive until the CPU reads them. Software sees four word registers:
//   0 STATUS, 1 DATA (pop), 2 CTRL (ie / flush / ovf clear), 3 THRESH.
// A bus access starts on any edge where cs_i is high and ack_o is low. All side
// effects happen on that start edge. ack_o is a one-cycle pulse, and dat_o is
// registered and holds its value until the next read.
// int_o is a registered level: ie && (count >= thresh || ovf).

module kb_fifo_ctrl #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cs_i,
    input  logic              we_i,
    input  logic [31:0]       adr_i,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    output logic              ack_o,
    output logic              int_o,
    input  logic [DATA_W-1:0] data,
    input  logic              ready
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_DATA   = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } reg_addr_e;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic              ie;
    logic [CNT_W-1:0]  thresh;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    reg_addr_e reg_sel;
    logic      acc_start;
    logic      rd_acc;
    logic      wr_acc;
    logic      ctrl_wr;
    logic      thresh_wr_en;

    assign reg_sel      = reg_addr_e'(adr_i[3:2]);
    assign acc_start    = cs_i & ~ack_o;
    assign rd_acc       = acc_start & ~we_i;
    assign wr_acc       = acc_start & we_i;
    assign ctrl_wr      = wr_acc && (reg_sel == REG_CTRL);
    assign thresh_wr_en = wr_acc && (reg_sel == REG_THRESH);

    // Address bits outside [3:2] and the undefined data bits are ignored.
    logic unused_bits;
    assign unused_bits = ^{adr_i[31:4], adr_i[1:0], dat_i[31:3]};

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic flush;
    logic ovf_clr;
    logic push;
    logic ovf_set;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    assign pop        = rd_acc && (reg_sel == REG_DATA) && !fifo_empty;
    assign flush      = ctrl_wr && dat_i[1];
    assign ovf_clr    = ctrl_wr && dat_i[2];
    // A pop on the same edge frees a slot, so a full FIFO still accepts the code.
    // A flush on the same edge discards the code without flagging overflow.
    assign push       = ready && !flush && (!fifo_full || pop);
    assign ovf_set    = ready && !flush && fifo_full && !pop;

    // ------------------------------------------------------------------
    // Next-state values (int_o is computed from these post-update values)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] count_next;
    logic             ovf_next;
    logic             ie_next;
    logic [CNT_W-1:0] thresh_next;
    logic [CNT_W-1:0] thresh_wdata;

    assign thresh_wdata = dat_i[CNT_W-1:0];
    // A new overflow on the same edge as a clear wins.
    assign ovf_next     = ovf_set | (ovf & ~ovf_clr);
    assign ie_next      = ctrl_wr ? dat_i[0] : ie;

    // Occupancy, threshold and interrupt-enable updates for this edge.
    // NOTE: every signal assigned in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next  = count;
        thresh_next = thresh;

        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count - CNT_ONE;
        end

        if (thresh_wr_en) begin
            if (thresh_wdata == '0) begin
                thresh_next = CNT_ONE;
            end else if (thresh_wdata > DEPTH_C) begin
                thresh_next = DEPTH_C;
            end else begin
                thresh_next = thresh_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data: reflects state before this edge's updates
    // ------------------------------------------------------------------
    logic [31:0] rd_data;
    logic [31:0] count_ext;

    assign count_ext = 32'(count);

    // Select the read word for the addressed register.
    always_comb begin
        rd_data = '0;
        unique case (reg_sel)
            REG_STATUS: begin
                rd_data[0]    = !fifo_empty;
                rd_data[1]    = fifo_full;
                rd_data[2]    = ovf;
                rd_data[3]    = ie;
                rd_data[15:8] = count_ext[7:0];
            end
            REG_DATA: begin
                if (!fifo_empty) begin
                    rd_data[31]         = 1'b1;
                    rd_data[DATA_W-1:0] = mem[rd_ptr];
                end
            end
            REG_CTRL: begin
                rd_data[0] = ie;
            end
            REG_THRESH: begin
                rd_data = 32'(thresh);
            end
            default: begin
                rd_data = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Pointers, occupancy, flags, bus handshake and interrupt register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            ie     <= 1'b0;
            thresh <= CNT_ONE;
            dat_o  <= '0;
            ack_o  <= 1'b0;
            int_o  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            count  <= count_next;
            ovf    <= ovf_next;
            ie     <= ie_next;
            thresh <= thresh_next;

            ack_o <= acc_start;
            if (rd_acc) begin
                dat_o <= rd_data;
            end

            int_o <= ie_next && ((count_next >= thresh_next) || ovf_next);
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array has no reset; its contents are only observable
    // through count/rd_ptr, which are reset, so stale entries are never read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    // ------------------------------------------------------------------
    // Simulation-only invariants
    // ------------------------------------------------------------------
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= DEPTH_C);

    a_ack_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ack_o |=> !ack_o);

    a_thresh_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (thresh >= CNT_ONE) && (thresh <= DEPTH_C));

endmodule

// File: tb/tb_kb_fifo_ctrl.sv
// Self-checking bench for kb_fifo_ctrl. A queue-based reference model tracks the
// FIFO contents, flags and the expected registered outputs; directed scenarios
// also compare against literal values.

module tb_kb_fifo_ctrl;

    localparam int DEPTH = 16;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b1;
    logic        cs_i   = 1'b0;
    logic        we_i   = 1'b0;
    logic [31:0] adr_i  = '0;
    logic [31:0] dat_i  = '0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        int_o;
    logic [7:0]  data   = '0;
    logic        ready  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  q[$];
    bit          m_ovf;
    bit          m_ie;
    bit          m_ack;
    bit          m_int;
    int          m_thresh;
    logic [31:0] m_dat;

    kb_fifo_ctrl #(
        .DATA_W    (8),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .cs_i  (cs_i),
        .we_i  (we_i),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .int_o (int_o),
        .data  (data),
        .ready (ready)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_ie     = 1'b0;
        m_ack    = 1'b0;
        m_int    = 1'b0;
        m_thresh = 1;
        m_dat    = '0;
    endfunction

    // One clock edge of the reference model.
    function automatic void model_step(input bit c, input bit w, input bit [1:0] a,
                                       input logic [31:0] wd, input bit r,
                                       input logic [7:0] code);
        bit start;
        bit pop;
        bit flush;
        bit new_ovf;
        int n;
        int t;
        start   = c && !m_ack;
        n       = q.size();
        new_ovf = 1'b0;
        m_ack   = start;
        if (start && !w) begin
            case (a)
                2'd0: m_dat = {16'h0, 8'(n), 4'h0, m_ie, m_ovf, (n == DEPTH), (n != 0)};
                2'd1: m_dat = (n > 0) ? {1'b1, 23'h0, q[0]} : 32'h0;
                2'd2: m_dat = {31'h0, m_ie};
                default: m_dat = 32'(m_thresh);
            endcase
        end
        pop   = start && !w && (a == 2'd1) && (n > 0);
        flush = start && w && (a == 2'd2) && wd[1];
        if (start && w && (a == 2'd2)) m_ie = wd[0];
        if (start && w && (a == 2'd3)) begin
            t = int'(wd[4:0]);
            if (t == 0) t = 1;
            else if (t > DEPTH) t = DEPTH;
            m_thresh = t;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (r) begin
                if (q.size() < DEPTH) q.push_back(code);
                else new_ovf = 1'b1;
            end
        end
        if (start && w && (a == 2'd2) && wd[2]) m_ovf = 1'b0;
        if (new_ovf) m_ovf = 1'b1;
        m_int = m_ie && ((q.size() >= m_thresh) || m_ovf);
    endfunction

    // Drive one cycle of inputs; returns at edge+1 with outputs settled.
    task automatic tick(input bit c, input bit w, input bit [1:0] a,
                        input logic [31:0] wd, input bit r, input logic [7:0] code);
        cs_i  = c;
        we_i  = w;
        adr_i = {28'h0, a, 2'b00};
        dat_i = wd;
        ready = r;
        data  = code;
        @(posedge clk_i);
        model_step(c, w, a, wd, r, code);
        #1;
        cs_i  = 1'b0;
        we_i  = 1'b0;
        ready = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic push(input logic [7:0] code);
        tick(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, code);
    endtask

    task automatic wr_reg(input bit [1:0] a, input logic [31:0] wd);
        tick(1'b1, 1'b1, a, wd, 1'b0, 8'h00);
        idle();
    endtask

    task automatic rd_reg(input bit [1:0] a, output logic [31:0] obs);
        tick(1'b1, 1'b0, a, 32'h0, 1'b0, 8'h00);
        obs = dat_o;
        idle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] obs;
        #1 rst_ni = 1'b0;
        #2;
        n_checks++;
        if ({dat_o, ack_o, int_o} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dat_o=%h ack_o=%b int_o=%b, want all 0", dat_o, ack_o, int_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;
        rd_reg(2'd0, obs);
        n_checks++;
        if (obs !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status: got %h want 00000000", obs);
        end
        n_checks++;
        if (int_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_int: got %b want 0", int_o);
        end
        rd_reg(2'd1, obs);
        n_checks++;
        if (obs !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data_empty: got %h want 00000000", obs);
        end
    endtask

    // cs held high: accesses start every other cycle; writes to STATUS still ack.
    task automatic test_bus_handshake();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 8'h00);
            n_checks++;
            if (ack_o !== ((i % 2) == 0)) begin
                n_fail++;
                $display("FAIL handshake_ack[%0d]: got %b want %b", i, ack_o, (i % 2) == 0);
            end
        end
        idle();
        tick(1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0, 8'h00);
        n_checks++;
        if (ack_o !== 1'b1 || dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL status_write_ack: got ack=%b dat=%h want ack=1 dat=00000000", ack_o, dat_o);
        end
        idle();
    endtask

    task automatic test_int_single();
        logic [31:0] obs;
        wr_reg(2'd2, 32'h1);
        n_checks++;
        if (int_o !== 1'b0) begin
            n_fail++;
            $display("FAIL int_idle: got %b want 0", int_o);
        end
        push(8'h1C);
        n_checks++;
        if (int_o !== 1'b1) begin
            n_fail++;
            $display("FAIL int_after_push: got %b want 1", int_o);
        end
        tick(1'b1, 1'b0, 2'd1, 32'h0, 1'b0, 8'h00);
        n_checks++;
        if (dat_o !== 32'h8000_001C || ack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_1c: got dat=%h ack=%b want 8000001c ack=1", dat_o, ack_o);
        end
        n_checks++;
        if (int_o !== 1'b0) begin
            n_fail++;
            $display("FAIL int_after_pop: got %b want 0", int_o);
        end
        idle();
        rd_reg(2'd0, obs);
        n_checks++;
        if (obs !== 32'h0000_0008) begin
            n_fail++;
            $display("FAIL status_after_pop: got %h want 00000008", obs);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] obs;
        wr_reg(2'd2, 32'h1);
        for (int i = 1; i <= 17; i++) push(8'(i));
        rd_reg(2'd0, obs);
        n_checks++;
        if (obs !== 32'h0000_100F) begin
            n_fail++;
            $display("FAIL status_overflow: got %h want 0000100f", obs);
        end
        for (int i = 1; i <= 17; i++) begin
            rd_reg(2'd1, obs);
            n_checks++;
            if (obs !== ((i <= 16) ? (32'h8000_0000 | 32'(i)) : 32'h0)) begin
                n_fail++;
                $display("FAIL drain_read[%0d]: got %h want %h", i, obs,
                         (i <= 16) ? (32'h8000_0000 | 32'(i)) : 32'h0);
            end
        end
        n_checks++;
        if (int_o !== 1'b1) begin
            n_fail++;
            $display("FAIL int_sticky_ovf: got %b want 1", int_o);
        end
        wr_reg(2'd2, 32'h4);
        rd_reg(2'd0, obs);
        n_checks++;
        if (obs !== 32'h0 || int_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got status=%h int=%b want 00000000 int=0", obs, int_o);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] obs;
        logic [7:0]  first;
        int          op;
        wr_reg(2'd2, 32'h1);
        first = 8'($urandom);
        push(first);
        for (int i = 1; i < DEPTH; i++) push(8'($urandom));
        tick(1'b1, 1'b0, 2'd1, 32'h0, 1'b1, 8'($urandom));
        n_checks++;
        if (dat_o !== {1'b1, 23'h0, first}) begin
            n_fail++;
            $display("FAIL full_pop_push: got %h want %h", dat_o, {1'b1, 23'h0, first});
        end
        idle();
        rd_reg(2'd0, obs);
        n_checks++;
        if (obs !== 32'h0000_100B) begin
            n_fail++;
            $display("FAIL full_pop_push_status: got %h want 0000100b", obs);
        end
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            tick((op == 1) || (op == 2), 1'b0, 2'd1, 32'h0, (op == 0) || (op == 2), 8'($urandom));
            n_checks++;
            if (dat_o !== m_dat || ack_o !== m_ack || int_o !== m_int) begin
                n_fail++;
                $display("FAIL mixed_op[%0d]: got dat=%h ack=%b int=%b want dat=%h ack=%b int=%b",
                         i, dat_o, ack_o, int_o, m_dat, m_ack, m_int);
            end
        end
        idle();
        for (int i = 0; i < DEPTH + 1; i++) begin
            rd_reg(2'd1, obs);
            n_checks++;
            if (obs !== m_dat) begin
                n_fail++;
                $display("FAIL wrap_drain[%0d]: got %h want %h", i, obs, m_dat);
            end
        end
    endtask

    task automatic test_threshold_flush();
        logic [31:0] obs;
        wr_reg(2'd2, 32'h6);
        wr_reg(2'd3, 32'h4);
        wr_reg(2'd2, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            push(8'h40 + 8'(i));
            n_checks++;
            if (int_o !== (i == 4)) begin
                n_fail++;
                $display("FAIL thresh_int[%0d]: got %b want %b", i, int_o, i == 4);
            end
        end
        tick(1'b1, 1'b1, 2'd2, 32'h3, 1'b1, 8'hEE);
        n_checks++;
        if (int_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_int: got %b want 0", int_o);
        end
        idle();
        rd_reg(2'd0, obs);
        n_checks++;
        if (obs !== 32'h0000_0008) begin
            n_fail++;
            $display("FAIL flush_status: got %h want 00000008", obs);
        end
        rd_reg(2'd1, obs);
        n_checks++;
        if (obs !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_discard: got %h want 00000000", obs);
        end
    endtask

    task automatic test_thresh_clamp();
        logic [31:0] obs;
        logic [31:0] wv [5] = '{32'd0, 32'd31, 32'd16, 32'd17, 32'd9};
        logic [31:0] ev [5] = '{32'd1, 32'd16, 32'd16, 32'd16, 32'd9};
        for (int i = 0; i < 5; i++) begin
            wr_reg(2'd3, wv[i]);
            rd_reg(2'd3, obs);
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL thresh_clamp[%0d]: wrote %0d got %h want %h", i, wv[i], obs, ev[i]);
            end
        end
        rd_reg(2'd2, obs);
        n_checks++;
        if (obs !== 32'h1) begin
            n_fail++;
            $display("FAIL ctrl_read: got %h want 00000001", obs);
        end
        wr_reg(2'd3, 32'h1);
    endtask

    task automatic test_random();
        bit          c;
        bit          w;
        bit [1:0]    a;
        logic [31:0] wd;
        for (int i = 0; i < 300; i++) begin
            c  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            a  = 2'($urandom_range(0, 3));
            wd = $urandom;
            if (a == 2'd2 && $urandom_range(0, 7) != 0) wd[1] = 1'b0;
            tick(c, w, a, wd, 1'($urandom_range(0, 1)), 8'($urandom));
            n_checks++;
            if (dat_o !== m_dat || ack_o !== m_ack || int_o !== m_int) begin
                n_fail++;
                $display("FAIL random[%0d]: got dat=%h ack=%b int=%b want dat=%h ack=%b int=%b",
                         i, dat_o, ack_o, int_o, m_dat, m_ack, m_int);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        logic [31:0] obs;
        wr_reg(2'd2, 32'h6);
        wr_reg(2'd2, 32'h1);
        wr_reg(2'd3, 32'h1);
        for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
        tick(1'b1, 1'b0, 2'd1, 32'h0, 1'b0, 8'h00);
        n_checks++;
        if (dat_o !== 32'h8000_00A0 || ack_o !== 1'b1 || int_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got dat=%h ack=%b int=%b want 800000a0 ack=1 int=1", dat_o, ack_o, int_o);
        end
        ready = 1'b1;
        data  = 8'h55;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({dat_o, ack_o, int_o} !== 34'h0) begin
            n_fail++;
            $display("FAIL async_reset: got dat=%h ack=%b int=%b want all 0", dat_o, ack_o, int_o);
        end
        repeat (2) @(posedge clk_i);
        ready = 1'b0;
        @(negedge clk_i) rst_ni = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;
        rd_reg(2'd0, obs);
        n_checks++;
        if (obs !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_status: got %h want 00000000", obs);
        end
        rd_reg(2'd3, obs);
        n_checks++;
        if (obs !== 32'h1) begin
            n_fail++;
            $display("FAIL post_reset_thresh: got %h want 00000001", obs);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bus_handshake();
        test_int_single();
        test_overflow();
        test_full_push_pop();
        test_threshold_flush();
        test_thresh_clamp();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
